// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared control types for the data-memory path:
//   mem_op_t     access size / sign-extension code (RISC-V funct3 encoding)
//   arb_state_t  arbiter FSM states
//   PORT_CPU / PORT_DBG  port indices used by the arbiter and its picker
//   op_misaligned()      alignment check for a given op/address pair
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Size is carried in op[1:0]; sign handling in op[2] does not affect alignment.
    function automatic logic op_misaligned(input mem_op_t op, input logic [31:0] addr);
        logic w_bad;
        case (op[1:0])
            2'b10:   w_bad = (addr[1:0] != 2'b00);
            2'b01:   w_bad = addr[0];
            default: w_bad = 1'b0;
        endcase
        return w_bad;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Two-requester picker producing a one-hot winner.
//   i_req0, i_req1 : requests from PORT_CPU / PORT_DBG
//   i_prio         : port that wins when both request (RR pointer, or PORT_CPU)
//   o_win[1:0]     : one-hot winner, bit index = port index; 0 when no request
// -----------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_prio,
    output logic [1:0] o_win
);

    always_comb begin
        o_win = {i_req1, i_req0};
        if (i_req0 && i_req1) begin
            o_win = (i_prio == PORT_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of a single data memory (combinational read,
// clocked write). Port 0 is the CPU, port 1 the loader/debug port.
// One access every two cycles: IDLE/RESP -> ACCESS (gnt) -> RESP (rvalid).
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   pN_req/we/op/addr/wdata    request side of port N (held until pN_gnt)
//   pN_gnt                     high for the ACCESS cycle of port N's request
//   pN_rvalid/rdata/err        one-cycle response in RESP; rdata 0 for writes
//                              and errors; err flags range/alignment faults
//   mem_wr_en/op/addr/data_in  memory command, driven from the holding register
//   mem_data_out               memory read data, captured at end of ACCESS
//   conflict_cnt               saturating count of arbitrations with both reqs
//
// Build option: define DMEM_ARB_RR_EN for round-robin on conflict; otherwise
// port 0 always wins and no pointer register exists.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_SIZE_BYTES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p0_req,
    input  logic             p0_we,
    input  mem_op_t          p0_op,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [31:0]      p0_rdata,
    output logic             p0_err,

    input  logic             p1_req,
    input  logic             p1_we,
    input  mem_op_t          p1_op,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [31:0]      p1_rdata,
    output logic             p1_err,

    output logic             mem_wr_en,
    output mem_op_t          mem_op,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data_in,
    input  logic [31:0]      mem_data_out,

    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE_BYTES);

    arb_state_t       r_state;
    logic             r_we;
    mem_op_t          r_op;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_illegal;
    logic             r_wr_en;
    logic [1:0]       r_gnt;
    logic [1:0]       r_rvalid;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_prio;
    logic [1:0]       w_win;
    logic             w_sel;
    logic             w_any;
    logic             w_both;
    logic             w_we;
    mem_op_t          w_op;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic             w_illegal;

`ifdef DMEM_ARB_RR_EN
    // Points at the port that wins the next conflict.
    logic             r_rr_ptr;
    assign w_prio = r_rr_ptr;
`else
    assign w_prio = PORT_CPU;
`endif

    dmem_arb_pick u_pick (
        .i_req0 (p0_req),
        .i_req1 (p1_req),
        .i_prio (w_prio),
        .o_win  (w_win)
    );

    assign w_any  = p0_req | p1_req;
    assign w_both = p0_req & p1_req;
    assign w_sel  = w_win[1];

    assign w_we      = w_sel ? p1_we    : p0_we;
    assign w_op      = w_sel ? p1_op    : p0_op;
    assign w_addr    = w_sel ? p1_addr  : p0_addr;
    assign w_wdata   = w_sel ? p1_wdata : p0_wdata;
    assign w_illegal = (w_addr >= MEM_LIMIT) | op_misaligned(w_op, w_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_we      <= 1'b0;
            r_op      <= MEM_B;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_illegal <= 1'b0;
            r_wr_en   <= 1'b0;
            r_gnt     <= 2'b00;
            r_rvalid  <= 2'b00;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0;
            r_cnt     <= '0;
`ifdef DMEM_ARB_RR_EN
            r_rr_ptr  <= PORT_CPU;
`endif
        end else begin
            case (r_state)
                ARB_IDLE, ARB_RESP: begin
                    // Response lasts exactly one cycle.
                    r_rvalid <= 2'b00;
                    r_err    <= 1'b0;
                    r_rdata  <= 32'h0;
                    if (w_any) begin
                        r_state   <= ARB_ACCESS;
                        r_we      <= w_we;
                        r_op      <= w_op;
                        r_addr    <= w_addr;
                        r_wdata   <= w_wdata;
                        r_illegal <= w_illegal;
                        r_wr_en   <= w_we & ~w_illegal;
                        r_gnt     <= w_win;
                        if (w_both && (r_cnt != {CNT_W{1'b1}})) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`ifdef DMEM_ARB_RR_EN
                        r_rr_ptr  <= ~w_sel;
`endif
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_ACCESS: begin
                    r_state  <= ARB_RESP;
                    r_gnt    <= 2'b00;
                    r_wr_en  <= 1'b0;
                    // Grant vector doubles as the response owner.
                    r_rvalid <= r_gnt;
                    r_err    <= r_illegal;
                    r_rdata  <= (r_we | r_illegal) ? 32'h0 : mem_data_out;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign p0_gnt    = r_gnt[0];
    assign p1_gnt    = r_gnt[1];
    assign p0_rvalid = r_rvalid[0];
    assign p1_rvalid = r_rvalid[1];
    assign p0_err    = r_err & r_rvalid[0];
    assign p1_err    = r_err & r_rvalid[1];
    assign p0_rdata  = r_rvalid[0] ? r_rdata : 32'h0;
    assign p1_rdata  = r_rvalid[1] ? r_rdata : 32'h0;

    assign mem_wr_en    = r_wr_en;
    assign mem_op       = r_op;
    assign mem_addr     = r_addr;
    assign mem_data_in  = r_wdata;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a byte-array memory model attached.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             p0_req, p0_we, p1_req, p1_we;
    mem_op_t          p0_op, p1_op;
    logic [31:0]      p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic             p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0]      p0_rdata, p1_rdata;
    logic             mem_wr_en;
    mem_op_t          mem_op;
    logic [31:0]      mem_addr, mem_data_in, mem_data_out;
    logic [CNT_W-1:0] conflict_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_wr   = 0;
    int n_rv0  = 0;

    logic [7:0]  mem [0:1023] = '{default: 8'h00};
    logic [31:0] w_raw;

    dmem_arbiter #(.MEM_SIZE_BYTES(1024), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_op        (p0_op),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_gnt       (p0_gnt),
        .p0_rvalid    (p0_rvalid),
        .p0_rdata     (p0_rdata),
        .p0_err       (p0_err),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_op        (p1_op),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_gnt       (p1_gnt),
        .p1_rvalid    (p1_rvalid),
        .p1_rdata     (p1_rdata),
        .p1_err       (p1_err),
        .mem_wr_en    (mem_wr_en),
        .mem_op       (mem_op),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian memory: combinational read, clocked write.
    always_comb begin
        w_raw = {mem[mem_addr[9:0] + 10'd3], mem[mem_addr[9:0] + 10'd2],
                 mem[mem_addr[9:0] + 10'd1], mem[mem_addr[9:0]]};
        case (mem_op)
            MEM_B:   mem_data_out = {{24{w_raw[7]}}, w_raw[7:0]};
            MEM_BU:  mem_data_out = {24'h0, w_raw[7:0]};
            MEM_H:   mem_data_out = {{16{w_raw[15]}}, w_raw[15:0]};
            MEM_HU:  mem_data_out = {16'h0, w_raw[15:0]};
            default: mem_data_out = w_raw;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            n_wr <= n_wr + 1;
            mem[mem_addr[9:0]] <= mem_data_in[7:0];
            if (mem_op[1:0] != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_data_in[15:8];
            if (mem_op[1:0] == 2'b10) begin
                mem[mem_addr[9:0] + 10'd2] <= mem_data_in[23:16];
                mem[mem_addr[9:0] + 10'd3] <= mem_data_in[31:24];
            end
        end
        if (p0_rvalid) n_rv0 <= n_rv0 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic p0_set(input logic req, input logic we, input mem_op_t op,
                          input logic [31:0] addr, input logic [31:0] wdata);
        p0_req = req; p0_we = we; p0_op = op; p0_addr = addr; p0_wdata = wdata;
    endtask

    task automatic p1_set(input logic req, input logic we, input mem_op_t op,
                          input logic [31:0] addr, input logic [31:0] wdata);
        p1_req = req; p1_we = we; p1_op = op; p1_addr = addr; p1_wdata = wdata;
    endtask

    initial begin
        int wr0, rv0;
        logic [1:0] exp_g;

        reset = 1'b1;
        p0_set(1'b0, 1'b0, MEM_B, 32'h0, 32'h0);
        p1_set(1'b0, 1'b0, MEM_B, 32'h0, 32'h0);
        tick(); tick();

        // Reset state
        chk("rst_flags", 32'({p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_wr_en}), 32'h0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'h0);
        chk("rst_mem_cmd", mem_addr | mem_data_in | 32'(mem_op), 32'h0);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);
        reset = 1'b0;
        tick();

        // p0 word write 0x0a to 0x200, then word read back
        p0_set(1'b1, 1'b1, MEM_W, 32'h200, 32'h0000000a);
        tick();
        chk("wr_gnt", 32'({p1_gnt, p0_gnt}), 32'h1);
        chk("wr_wren", 32'(mem_wr_en), 32'h1);
        chk("wr_no_early_rvalid", 32'(p0_rvalid), 32'h0);
        p0_req = 1'b0;
        tick();
        chk("wr_resp", 32'({p0_rvalid, p0_err}), 32'h2);
        chk("wr_rdata", p0_rdata, 32'h0);
        chk("wr_mem512", 32'(mem[512]), 32'h0a);
        chk("wr_wren_off", 32'(mem_wr_en), 32'h0);
        p0_set(1'b1, 1'b0, MEM_W, 32'h200, 32'h0);
        tick();
        chk("rd_gnt", 32'(p0_gnt), 32'h1);
        chk("rd_no_wren", 32'(mem_wr_en), 32'h0);
        p0_req = 1'b0;
        tick();
        chk("rd_resp", 32'({p0_rvalid, p0_err}), 32'h2);
        chk("rd_rdata", p0_rdata, 32'h0000000a);
        tick();
        chk("rd_rvalid_pulse", 32'(p0_rvalid), 32'h0);
        chk("rd_rdata_idle", p0_rdata, 32'h0);

        // Fresh reset so the round-robin pointer starts at p0
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();

        // Both ports read together for four arbitrations
        p0_set(1'b1, 1'b0, MEM_W, 32'h200, 32'h0);
        p1_set(1'b1, 1'b0, MEM_W, 32'h204, 32'h0);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            tick();
            chk($sformatf("conf_gnt%0d", i), 32'({p1_gnt, p0_gnt}), 32'(exp_g));
            if (i == 3) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            tick();
            chk($sformatf("conf_rvalid%0d", i), 32'({p1_rvalid, p1_err, p0_rvalid, p0_err}),
                exp_g[0] ? 32'h2 : 32'h8);
            chk($sformatf("conf_rdata%0d", i), p0_rdata | p1_rdata, exp_g[0] ? 32'h0000000a : 32'h0);
        end
        tick();
        chk("conf_cnt", 32'(conflict_cnt), 32'd4);
        chk("conf_idle", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}), 32'h0);

        // Reset for two cycles in the middle of a p0 read
        p0_set(1'b1, 1'b0, MEM_W, 32'h200, 32'h0);
        tick();
        chk("mid_gnt", 32'(p0_gnt), 32'h1);
        p0_req = 1'b0;
        reset = 1'b1;
        tick(); tick();
        chk("mid_flags", 32'({p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_wr_en}), 32'h0);
        chk("mid_cnt", 32'(conflict_cnt), 32'h0);
        chk("mid_state", 32'(dut.r_state), 32'(ARB_IDLE));
        chk("mid_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;
        tick();
        chk("mid_no_rvalid", 32'(p0_rvalid), 32'h0);

        // p1 word write out of range
        wr0 = n_wr;
        p1_set(1'b1, 1'b1, MEM_W, 32'h400, 32'h12345678);
        tick();
        chk("oor_gnt", 32'({p1_gnt, p0_gnt}), 32'h2);
        chk("oor_wren", 32'(mem_wr_en), 32'h0);
        p1_req = 1'b0;
        tick();
        chk("oor_resp", 32'({p1_rvalid, p1_err, p0_rvalid}), 32'h6);
        chk("oor_rdata", p1_rdata, 32'h0);
        chk("oor_no_write", 32'(n_wr - wr0), 32'h0);
        tick();

        // Alignment: word at 0x201 faults, halfword at 0x202 is fine
        p0_set(1'b1, 1'b0, MEM_W, 32'h201, 32'h0);
        tick();
        p0_req = 1'b0;
        tick();
        chk("mis_w_resp", 32'({p0_rvalid, p0_err}), 32'h3);
        chk("mis_w_rdata", p0_rdata, 32'h0);
        tick();
        p0_set(1'b1, 1'b0, MEM_H, 32'h202, 32'h0);
        tick();
        p0_req = 1'b0;
        tick();
        chk("al_h_resp", 32'({p0_rvalid, p0_err}), 32'h2);
        chk("al_h_rdata", p0_rdata, 32'h0);
        tick();

        // Reset during the ACCESS cycle of a p0 write
        rv0 = n_rv0;
        wr0 = n_wr;
        p0_set(1'b1, 1'b1, MEM_W, 32'h300, 32'hdeadbeef);
        tick();
        chk("rstacc_wren_on", 32'(mem_wr_en), 32'h1);
        p0_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstacc_wren_off", 32'(mem_wr_en), 32'h0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("rstacc_mem", {mem[771], mem[770], mem[769], mem[768]}, 32'h0);
        chk("rstacc_no_write", 32'(n_wr - wr0), 32'h0);
        chk("rstacc_no_rvalid", 32'(n_rv0 - rv0), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_SIZE_BYTES, default 1024, data memory size in bytes, used for range check.
REQ-002 SHALL have parameter CNT_W, default 16, conflict counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports p0_req/p1_req  in  1  access request; p0 = CPU, p1 = loader/debug.
REQ-006 SHALL have ports pN_we  in  1 (write), pN_op  in  mem_op_t (access size/sign), pN_addr  in  32, pN_wdata  in  32.
REQ-007 SHALL have ports pN_gnt  out  1 (request accepted), pN_rvalid  out  1 (response), pN_rdata  out  32, pN_err  out  1 (valid with pN_rvalid).
REQ-008 SHALL have ports mem_wr_en  out  1, mem_op  out  mem_op_t, mem_addr  out  32, mem_data_in  out  32, mem_data_out  in  32 (data memory, combinational read, clocked write).
REQ-009 SHALL have port conflict_cnt  out  CNT_W  count of cycles in which both requests were arbitrated together.

Function
REQ-010 SHALL implement FSM IDLE, ACCESS, RESP; IDLE->ACCESS and RESP->ACCESS when either req is high at the edge, else ->IDLE; ACCESS->RESP unconditionally.
REQ-011 SHALL, on entering ACCESS, latch winner's we/op/addr/wdata into a holding register and assert that port's gnt for exactly the ACCESS cycle.
REQ-012 SHALL drive mem_op/mem_addr/mem_data_in from the holding register; mem_wr_en high only during ACCESS for a legal write.
REQ-013 SHALL capture mem_data_out at end of ACCESS; in RESP pulse owner's rvalid for one cycle with rdata (reads) or zero (writes).
REQ-014 Latency: req sampled at edge N -> gnt in cycle N+1 -> rvalid in cycle N+2; sustained throughput one access per 2 cycles.
REQ-015 Requester SHALL hold req and fields stable until gnt; a req still high in RESP is a new request.
REQ-016 Fixed priority: p0 wins on simultaneous req.
REQ-017 Illegal access (addr >= MEM_SIZE_BYTES, word with addr[1:0]!=0, halfword with addr[0]!=0): no mem_wr_en, rvalid with err=1, rdata=0.
REQ-018 conflict_cnt SHALL increment when both reqs high at an arbitration edge; saturate at all-ones.
REQ-019 Non-owner gnt/rvalid/err SHALL be 0; rdata SHALL be 0 when rvalid is 0.

Reset
REQ-020 reset SHALL asynchronously force IDLE, all outputs and holding register to 0, conflict_cnt 0, RR pointer to p0.
REQ-021 Reset during ACCESS/RESP SHALL drop the transaction: mem_wr_en low immediately, no rvalid afterwards.

Configuration
REQ-022 With DMEM_ARB_RR_EN defined: round-robin; on conflict grant the port not granted last; pointer updates on every grant.
REQ-023 Without DMEM_ARB_RR_EN: fixed priority per REQ-016; no pointer register.

Structure
REQ-024 mem_op_t SHALL stay in the shared control-types package; arb_state_t and port index constants (PORT_CPU=0, PORT_DBG=1) SHALL be added there.
REQ-025 Arbitration SHALL be a sub-module dmem_arb_pick (two reqs, RR pointer -> one-hot winner); FSM and datapath in dmem_arbiter.

Verification
REQ-026 reset high 2 cycles mid-run -> all outputs 0, conflict_cnt 0, FSM IDLE.
REQ-027 p0 word write 0x0000000a to 0x200, then word read 0x200 -> memory byte 512 = 0x0a; p0_rvalid 2 cycles after req, p0_rdata 0x0000000a, err 0.
REQ-028 p0 and p1 reads high together for 4 arbitrations -> fixed: p0 gnt every time, p1 starves; RR: gnt alternates p0,p1,p0,p1; conflict_cnt = 4.
REQ-029 p1 word write to 0x400 -> mem_wr_en never high, p1_rvalid with p1_err=1, p1_rdata 0.
REQ-030 p0 word read at 0x201 -> p0_err=1; halfword read at 0x202 -> err=0.
REQ-031 reset asserted in ACCESS of a p0 write -> mem_wr_en falls same cycle, target byte unchanged, no p0_rvalid.
